// File: rtl/rx_block_assembler.sv
// RX block assembler: packs 32-bit FIFO words into 128-bit blocks,
// or passes words straight through in mode 00.
module rx_block_assembler #(
    parameter int FRAME_BLOCKS = 1584,
    parameter int MB_WORDS     = 396
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode_select,
    input  logic [31:0]  FIFO_rx_dout,
    input  logic         FIFO_rx_empty,
    output logic         FIFO_rx_rd_en,
    output logic [127:0] block_flat,
    output logic         residual_valid,
    output logic         quantized_valid,
    input  logic         block_ready,
    output logic [31:0]  MB_flat,
    output logic         MB_valid,
    output logic         frame_complete,
    output logic         Assembler_busy
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_DATA, HOLD} state_t;

    localparam logic [15:0] BLK_LAST = 16'(FRAME_BLOCKS - 1);
    localparam logic [15:0] MB_LAST  = 16'(MB_WORDS - 1);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        word_cnt_q, word_cnt_d;
    logic [15:0]       blk_cnt_q, blk_cnt_d;
    logic [15:0]       mb_cnt_q, mb_cnt_d;
    logic [3:0][31:0]  blk_q, blk_d;
    logic [31:0]       mb_flat_q, mb_flat_d;
    logic              mb_valid_q, mb_valid_d;
    logic              mb_last_q, mb_last_d;
    logic              frame_q, frame_d;

    logic capture, is_mb, accept, blk_last, mb_last;

    assign capture  = (state_q == WAIT_DATA);
    assign is_mb    = (mode_q == 2'b00);
    assign accept   = (state_q == HOLD) && block_ready;
    assign blk_last = (blk_cnt_q == BLK_LAST);
    assign mb_last  = (mb_cnt_q == MB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            word_cnt_q <= 2'd0;
            blk_cnt_q  <= 16'd0;
            mb_cnt_q   <= 16'd0;
            blk_q      <= '0;
            mb_flat_q  <= 32'd0;
            mb_valid_q <= 1'b0;
            mb_last_q  <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            word_cnt_q <= word_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
            mb_cnt_q   <= mb_cnt_d;
            blk_q      <= blk_d;
            mb_flat_q  <= mb_flat_d;
            mb_valid_q <= mb_valid_d;
            mb_last_q  <= mb_last_d;
            frame_q    <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mode_select != 2'b11 && !FIFO_rx_empty) state_d = FETCH;
            end
            FETCH: begin
                if (!FIFO_rx_empty) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (is_mb) state_d = mb_last ? IDLE : FETCH;
                else       state_d = (word_cnt_q == 2'd3) ? HOLD : FETCH;
            end
            HOLD: begin
                if (block_ready) state_d = blk_last ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Mode is only sampled while idle so a frame never switches type midway.
    always_comb begin
        mode_d     = (state_q == IDLE) ? mode_select : mode_q;
        word_cnt_d = word_cnt_q;
        blk_d      = blk_q;
        blk_cnt_d  = blk_cnt_q;
        mb_cnt_d   = mb_cnt_q;
        mb_flat_d  = mb_flat_q;
        mb_valid_d = 1'b0;
        mb_last_d  = 1'b0;
        if (capture && !is_mb) begin
            blk_d[word_cnt_q] = FIFO_rx_dout;
            word_cnt_d        = word_cnt_q + 2'd1;
        end
        if (capture && is_mb) begin
            mb_flat_d  = FIFO_rx_dout;
            mb_valid_d = 1'b1;
            mb_last_d  = mb_last;
            mb_cnt_d   = mb_last ? 16'd0 : mb_cnt_q + 16'd1;
        end
        if (accept) blk_cnt_d = blk_last ? 16'd0 : blk_cnt_q + 16'd1;
        frame_d = (mb_valid_q && mb_last_q) || (accept && blk_last);
    end

    always_comb begin
        FIFO_rx_rd_en   = !rst && (state_q == FETCH) && !FIFO_rx_empty;
        Assembler_busy  = !rst && (state_q != IDLE);
        residual_valid  = !rst && (state_q == HOLD) && (mode_q == 2'b01);
        quantized_valid = !rst && (state_q == HOLD) && (mode_q == 2'b10);
        MB_valid        = !rst && mb_valid_q;
        frame_complete  = !rst && frame_q;
        block_flat      = rst ? 128'd0 : blk_q;
        MB_flat         = rst ? 32'd0 : mb_flat_q;
    end

endmodule

// File: tb/tb_rx_block_assembler.sv
// Bench for rx_block_assembler: FIFO model, directed and random
// scenarios checked against expectations built from the pushed words.
module tb_rx_block_assembler;

    localparam int FB = 3;
    localparam int MW = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode_select;
    logic [31:0]  FIFO_rx_dout;
    logic         FIFO_rx_empty;
    logic         FIFO_rx_rd_en;
    logic [127:0] block_flat;
    logic         residual_valid;
    logic         quantized_valid;
    logic         block_ready;
    logic [31:0]  MB_flat;
    logic         MB_valid;
    logic         frame_complete;
    logic         Assembler_busy;

    always #5 clk = ~clk;

    rx_block_assembler #(.FRAME_BLOCKS(FB), .MB_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .mode_select(mode_select),
        .FIFO_rx_dout(FIFO_rx_dout), .FIFO_rx_empty(FIFO_rx_empty),
        .FIFO_rx_rd_en(FIFO_rx_rd_en), .block_flat(block_flat),
        .residual_valid(residual_valid), .quantized_valid(quantized_valid),
        .block_ready(block_ready), .MB_flat(MB_flat), .MB_valid(MB_valid),
        .frame_complete(frame_complete), .Assembler_busy(Assembler_busy)
    );

    // FIFO model: data appears the cycle after a granted read.
    logic [31:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign FIFO_rx_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (FIFO_rx_rd_en && !FIFO_rx_empty) begin
            FIFO_rx_dout <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end else begin
            FIFO_rx_dout <= $urandom;
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_reads = 0, bad_rd = 0, bad_hot = 0, bad_stable = 0, q_hi = 0;
    logic prev_v = 1'b0, prev_acc = 1'b0;
    logic [127:0] prev_flat = '0;
    logic [127:0] got_blk[$];
    logic [1:0]   got_kind[$];
    int           got_acc[$];
    logic [31:0]  got_mb[$];
    int           got_mbc[$];
    int           got_fc[$];
    int base, snap_r, snap_q;
    logic [31:0] wa, wb, wc;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    function automatic logic [127:0] exp_block(input int b);
        return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    endfunction

    task automatic clr();
        got_blk.delete(); got_kind.delete(); got_acc.delete();
        got_mb.delete(); got_mbc.delete(); got_fc.delete();
        n_reads = 0;
    endtask

    // Sample mid low phase; inputs now in place govern the next edge.
    task automatic tick();
        logic v, acc;
        #1;
        if (FIFO_rx_rd_en) begin
            n_reads++;
            if (FIFO_rx_empty) bad_rd++;
        end
        if (int'(residual_valid) + int'(quantized_valid)
            + int'(MB_valid) > 1) bad_hot++;
        if (quantized_valid) q_hi++;
        v = residual_valid | quantized_valid;
        if (v && prev_v && !prev_acc && block_flat !== prev_flat)
            bad_stable++;
        acc = v && block_ready;
        if (acc) begin
            got_blk.push_back(block_flat);
            got_kind.push_back({quantized_valid, residual_valid});
            got_acc.push_back(cyc);
        end
        if (MB_valid) begin
            got_mb.push_back(MB_flat);
            got_mbc.push_back(cyc);
        end
        if (frame_complete) got_fc.push_back(cyc);
        prev_v = v; prev_flat = block_flat; prev_acc = acc;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_blocks(input string tag, input int n,
                              input int b, input logic [1:0] kind);
        check({tag, "_count"}, 128'(got_blk.size()), 128'(n));
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"},
                  (i < got_blk.size()) ? got_blk[i] : 'x,
                  exp_block(b + 4 * i));
            if (kind != 2'b00)
                check({tag, "_kind"},
                      128'((i < got_kind.size()) ? got_kind[i] : 2'bxx),
                      128'(kind));
        end
    endtask

    task automatic chk_idle_out(input string tag);
        check({tag, "_ctl"}, 128'({FIFO_rx_rd_en, residual_valid,
              quantized_valid, MB_valid, frame_complete, Assembler_busy}),
              128'd0);
        check({tag, "_blk"}, block_flat, 128'd0);
        check({tag, "_mb"}, 128'(MB_flat), 128'd0);
    endtask

    initial begin
        rst = 1'b1; mode_select = 2'b00; block_ready = 1'b0;
        @(negedge clk);
        run(3);
        chk_idle_out("reset");
        rst = 1'b0;

        // Residual block from fixed words, then the rest of the frame
        mode_select = 2'b01; block_ready = 1'b1;
        clr(); base = rd_ptr;
        push(32'h11111111); push(32'h22222222);
        push(32'h33333333); push(32'h44444444);
        run(15);
        chk_blocks("res_fixed", 1, base, 2'b01);
        check("res_reads", 128'(n_reads), 128'd4);
        for (int i = 0; i < 8; i++) push($urandom);
        run(25);
        chk_blocks("res_frame", 3, base, 2'b01);
        check("frame_pulses", 128'(got_fc.size()), 128'd1);
        check("frame_timing", 128'((got_fc.size() > 0) ?
              got_fc[0] - got_acc[2] : -1), 128'd1);
        check("throughput", 128'((got_acc.size() > 2) ?
              (got_acc[2] - got_acc[1] <= 9) : 0), 128'd1);
        check("busy_after_frame", 128'(Assembler_busy), 128'd0);

        // Quantized block held under backpressure
        mode_select = 2'b10; block_ready = 1'b0;
        clr(); base = rd_ptr;
        for (int i = 0; i < 8; i++) push($urandom);
        run(10);
        check("hold_valid", 128'(quantized_valid), 128'd1);
        snap_r = n_reads; snap_q = q_hi;
        run(20);
        check("hold_no_reads", 128'(n_reads - snap_r), 128'd0);
        check("hold_valid_cycles", 128'(q_hi - snap_q), 128'd20);
        check("hold_none_taken", 128'(got_blk.size()), 128'd0);
        block_ready = 1'b1;
        run(14);
        chk_blocks("quant_bp", 2, base, 2'b10);

        // FIFO runs dry mid-block
        rst = 1'b1; tick(); rst = 1'b0;
        mode_select = 2'b01; clr(); base = rd_ptr;
        push($urandom); push($urandom);
        run(16);
        check("dry_reads", 128'(n_reads), 128'd2);
        push($urandom); push($urandom);
        run(10);
        chk_blocks("dry_block", 1, base, 2'b01);

        // Reset with two words captured and a third in flight
        push($urandom); push($urandom); push($urandom);
        run(5);
        rst = 1'b1; tick();
        chk_idle_out("midrst_during");
        rst = 1'b0;
        #1;
        chk_idle_out("midrst_after");
        clr(); base = rd_ptr;
        for (int i = 0; i < 4; i++) push($urandom);
        run(12);
        chk_blocks("post_rst", 1, base, 2'b01);

        // Mode change mid-frame only takes effect from idle
        rst = 1'b1; tick(); rst = 1'b0;
        mode_select = 2'b01; clr(); base = rd_ptr;
        push($urandom); push($urandom);
        run(4);
        mode_select = 2'b10;
        push($urandom); push($urandom);
        run(10);
        for (int i = 0; i < 8; i++) push($urandom);
        run(22);
        for (int i = 0; i < 4; i++) push($urandom);
        run(12);
        chk_blocks("mode_sw", 4, base, 2'b00);
        for (int i = 0; i < 4; i++)
            check("mode_sw_kind", 128'((i < got_kind.size()) ?
                  got_kind[i] : 2'bxx), 128'((i < 3) ? 2'b01 : 2'b10));

        // Halt mode, then word pass-through frame
        rst = 1'b1; mode_select = 2'b11; tick(); rst = 1'b0;
        clr();
        wa = $urandom; wb = $urandom; wc = $urandom;
        push(wa);
        run(8);
        check("halt_reads", 128'(n_reads), 128'd0);
        check("halt_busy", 128'(Assembler_busy), 128'd0);
        mode_select = 2'b00;
        push(wb); push(wc);
        run(14);
        check("mb_count", 128'(got_mb.size()), 128'd3);
        check("mb_a", 128'((got_mb.size() > 0) ? got_mb[0] : 'x), 128'(wa));
        check("mb_b", 128'((got_mb.size() > 1) ? got_mb[1] : 'x), 128'(wb));
        check("mb_c", 128'((got_mb.size() > 2) ? got_mb[2] : 'x), 128'(wc));
        check("mb_frame", 128'((got_fc.size() == 1 && got_mbc.size() == 3)
              ? got_fc[0] - got_mbc[2] : -1), 128'd1);
        check("mb_busy_after", 128'(Assembler_busy), 128'd0);
        check("mb_no_blocks", 128'(got_blk.size()), 128'd0);

        // Random arrivals and random backpressure over one frame
        rst = 1'b1; mode_select = 2'b10; tick(); rst = 1'b0;
        clr(); base = rd_ptr;
        for (int i = 0; i < 160; i++) begin
            if (wr_ptr - base < 12 && $urandom_range(0, 2) == 0)
                push($urandom);
            block_ready = 1'($urandom);
            tick();
        end
        while (wr_ptr - base < 12) push($urandom);
        block_ready = 1'b1;
        run(40);
        chk_blocks("rand_blk", 3, base, 2'b10);
        check("rand_frame", 128'(got_fc.size()), 128'd1);

        // Random pass-through words with gaps
        rst = 1'b1; mode_select = 2'b00; tick(); rst = 1'b0;
        clr(); base = rd_ptr;
        for (int i = 0; i < 60; i++) begin
            if (wr_ptr - base < 3 && $urandom_range(0, 3) == 0)
                push($urandom);
            tick();
        end
        while (wr_ptr - base < 3) push($urandom);
        run(12);
        check("rand_mb_count", 128'(got_mb.size()), 128'd3);
        for (int i = 0; i < 3; i++)
            check("rand_mb", 128'((i < got_mb.size()) ? got_mb[i] : 'x),
                  128'(mem[base + i]));
        check("rand_mb_frame", 128'(got_fc.size()), 128'd1);

        check("rd_while_empty", 128'(bad_rd), 128'd0);
        check("valid_onehot", 128'(bad_hot), 128'd0);
        check("hold_stable", 128'(bad_stable), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_block_assembler.md
RX_BLOCK_ASSEMBLER -- requirements
Module: rx_block_assembler

Interface
REQ-001 SHALL have parameter FRAME_BLOCKS, default 1584, meaning 128-bit blocks per frame (1..65535).
REQ-002 SHALL have parameter MB_WORDS, default 396, meaning 32-bit words per frame in mode 00 (1..65535).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mode_select  input  2  00 = word pass-through, 01 = residual blocks, 10 = quantized blocks, 11 = halt.
REQ-006 SHALL have port FIFO_rx_dout  input  32  RX FIFO read data; valid the cycle after FIFO_rx_rd_en was high.
REQ-007 SHALL have port FIFO_rx_empty  input  1  RX FIFO empty flag.
REQ-008 SHALL have port FIFO_rx_rd_en  output  1  RX FIFO read strobe.
REQ-009 SHALL have port block_flat  output  128  assembled block; word k in bits [32k+31:32k].
REQ-010 SHALL have port residual_valid  output  1  block_flat holds a residual block.
REQ-011 SHALL have port quantized_valid  output  1  block_flat holds a quantized block.
REQ-012 SHALL have port block_ready  input  1  downstream accepts block when high with a valid.
REQ-013 SHALL have port MB_flat  output  32  pass-through word.
REQ-014 SHALL have port MB_valid  output  1  one-cycle pulse, MB_flat valid.
REQ-015 SHALL have port frame_complete  output  1  one-cycle pulse after the last block/word of a frame.
REQ-016 SHALL have port Assembler_busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT_DATA, HOLD.
REQ-018 IDLE: SHALL latch mode_select into mode_r; 11 -> stay IDLE; 00/01/10 with FIFO_rx_empty low -> FETCH.
REQ-019 mode_select changes outside IDLE SHALL have no effect until return to IDLE.
REQ-020 FETCH: SHALL assert FIFO_rx_rd_en for one cycle only if FIFO_rx_empty is low, then go to WAIT_DATA; if empty, stay in FETCH with rd_en low.
REQ-021 WAIT_DATA: SHALL capture FIFO_rx_dout into word slot word_cnt (2-bit).
REQ-022 Mode 00, WAIT_DATA: SHALL drive MB_flat = captured word with MB_valid pulsed in the following cycle (capture-to-output latency 1 cycle), increment mb_cnt, return to FETCH; no backpressure.
REQ-023 Modes 01/10, WAIT_DATA: word_cnt < 3 -> increment, return to FETCH; word_cnt = 3 -> go to HOLD, word_cnt wraps to 0.
REQ-024 HOLD: SHALL assert residual_valid (mode_r=01) or quantized_valid (mode_r=10); block_flat SHALL stay stable until block_ready is sampled high.
REQ-025 HOLD with block_ready high: SHALL drop valid next cycle, increment blk_cnt, go to FETCH, or to IDLE if the frame ended.
REQ-026 At most one FIFO read SHALL be outstanding; rd_en SHALL never be high while FIFO_rx_empty is high.
REQ-027 Frame end: blk_cnt = FRAME_BLOCKS-1 accepted (modes 01/10) or mb_cnt = MB_WORDS-1 emitted (mode 00) -> frame_complete pulse one cycle, counter to 0, state to IDLE.
REQ-028 Counters SHALL be 16-bit and never exceed parameter-1.
REQ-029 Minimum block throughput SHALL be one block per 9 cycles with a non-empty FIFO and block_ready held high.
REQ-030 Only one of residual_valid, quantized_valid, MB_valid SHALL be high in any cycle.

Reset
REQ-031 rst high at any clock edge, including mid-block or during HOLD, SHALL force IDLE, discard partial words, and clear word_cnt, blk_cnt, mb_cnt, mode_r to 0.
REQ-032 During and after reset: FIFO_rx_rd_en, residual_valid, quantized_valid, MB_valid, frame_complete, Assembler_busy = 0; block_flat = 0; MB_flat = 0.
REQ-033 Any FIFO data returning the cycle after reset SHALL be ignored.

Verification
REQ-034 Mode 01, FIFO holds 0x11111111,0x22222222,0x33333333,0x44444444, block_ready=1 -> residual_valid once, block_flat = 0x44444444_33333333_22222222_11111111.
REQ-035 Mode 10, block_ready low 20 cycles in HOLD -> quantized_valid high and block_flat stable all 20 cycles, no rd_en, accepted on ready.
REQ-036 Mode 00, MB_WORDS=3, words A,B,C -> three MB_valid pulses carrying A,B,C, frame_complete one cycle after C's pulse, Assembler_busy low after.
REQ-037 FIFO goes empty after word 2 of a block for 10 cycles -> rd_en low throughout, block completes correctly when data resumes.
REQ-038 rst asserted after 2 words captured -> all outputs 0 next cycle; next 4 words form a clean block with no stale data.
REQ-039 mode_select toggled 01->10 mid-block -> current block flagged residual_valid; next frame uses quantized only after IDLE.
